// File: rtl/mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_n_counter
// Purpose  : Runtime-modulus up/down counter advanced by a one-cycle tick,
//            with clamped synchronous load, registered wrap pulse and a
//            combinational terminal-count flag. Stages cascade by feeding
//            wrap_pulse of one stage into tick of the next.
// Options  : MOD_N_COUNTER_HEX_EN adds hex_seg, an active-low seven-segment
//            decode of cur_value[3:0] (segments a..g on bits 0..6).
// Revision : 1.0 - initial release
// ============================================================================
module mod_n_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             tick,
  input  logic             up_down,
  input  logic [WIDTH-1:0] mod_value,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] cur_value,
  output logic             wrap_pulse,
  output logic             at_terminal
`ifdef MOD_N_COUNTER_HEX_EN
  ,
  output logic [6:0]       hex_seg
`endif
);

  localparam logic [WIDTH-1:0] C_RESET = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] cur_value_q, cur_value_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [WIDTH-1:0] w_m_max;
  logic             w_out_of_range;

  // Largest legal count M-1; a modulus of 0 behaves as a modulus of 1.
  assign w_m_max        = (mod_value == '0) ? '0 : (mod_value - WIDTH'(1));
  assign w_out_of_range = (cur_value_q > w_m_max);

  assign cur_value  = cur_value_q;
  assign wrap_pulse = wrap_pulse_q;

  // Terminal is direction-dependent; any out-of-range count also counts as terminal.
  assign at_terminal = w_out_of_range |
                       (up_down ? (cur_value_q == w_m_max) : (cur_value_q == '0));

  // Next-state selection: load beats tick beats hold; wrap only on a wrapping tick.
  always_comb begin
    cur_value_d  = cur_value_q;
    wrap_pulse_d = 1'b0;
    if (load) begin
      cur_value_d = (load_value > w_m_max) ? w_m_max : load_value;
    end else if (tick) begin
      if (up_down) begin
        if (cur_value_q >= w_m_max) begin
          cur_value_d  = '0;
          wrap_pulse_d = 1'b1;
        end else begin
          cur_value_d  = cur_value_q + WIDTH'(1);
        end
      end else begin
        if ((cur_value_q == '0) || w_out_of_range) begin
          cur_value_d  = w_m_max;
          wrap_pulse_d = 1'b1;
        end else begin
          cur_value_d  = cur_value_q - WIDTH'(1);
        end
      end
    end
  end

  // Count and wrap registers, cleared asynchronously by resetn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_value_q  <= C_RESET;
      wrap_pulse_q <= 1'b0;
    end else begin
      cur_value_q  <= cur_value_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

`ifdef MOD_N_COUNTER_HEX_EN
  logic [3:0] w_nibble;

  if (WIDTH >= 4) begin : g_nib_wide
    assign w_nibble = cur_value_q[3:0];
  end else begin : g_nib_narrow
    assign w_nibble = {{(4 - WIDTH){1'b0}}, cur_value_q};
  end

  // Active-low seven-segment decode, bit 0 = segment a ... bit 6 = segment g.
  always_comb begin
    hex_seg = 7'b1111111;
    case (w_nibble)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = 7'b1111111;
    endcase
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_n_counter
// Purpose  : Self-checking bench for mod_n_counter: directed scenarios, a
//            two-stage cascade and a randomized run against an integer model.
// Options  : MOD_N_COUNTER_HEX_EN enables the hex_seg checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_n_counter;

  logic       clk;
  logic       resetn;
  logic       tick, up_down, load;
  logic [3:0] mod_value, load_value;
  logic [3:0] cur_value;
  logic       wrap_pulse, at_terminal;

  logic       c_tick, c_up, c_load;
  logic [3:0] c_mod, c_lv;
  logic [3:0] c0_cur, c1_cur;
  logic       c0_wrap, c1_wrap, c0_at, c1_at;

`ifdef MOD_N_COUNTER_HEX_EN
  logic [6:0] hex_seg, c0_hex, c1_hex;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (plain integers)
  int m_cur;
  int m_wrap;

  mod_n_counter #(.WIDTH(4), .RESET_VALUE(5)) u_dut (
    .clk(clk), .resetn(resetn), .tick(tick), .up_down(up_down),
    .mod_value(mod_value), .load(load), .load_value(load_value),
    .cur_value(cur_value), .wrap_pulse(wrap_pulse), .at_terminal(at_terminal)
`ifdef MOD_N_COUNTER_HEX_EN
    , .hex_seg(hex_seg)
`endif
  );

  mod_n_counter #(.WIDTH(4), .RESET_VALUE(0)) u_c0 (
    .clk(clk), .resetn(resetn), .tick(c_tick), .up_down(c_up),
    .mod_value(c_mod), .load(c_load), .load_value(c_lv),
    .cur_value(c0_cur), .wrap_pulse(c0_wrap), .at_terminal(c0_at)
`ifdef MOD_N_COUNTER_HEX_EN
    , .hex_seg(c0_hex)
`endif
  );

  mod_n_counter #(.WIDTH(4), .RESET_VALUE(0)) u_c1 (
    .clk(clk), .resetn(resetn), .tick(c0_wrap), .up_down(c_up),
    .mod_value(c_mod), .load(c_load), .load_value(c_lv),
    .cur_value(c1_cur), .wrap_pulse(c1_wrap), .at_terminal(c1_at)
`ifdef MOD_N_COUNTER_HEX_EN
    , .hex_seg(c1_hex)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int eff_mod();
    return (mod_value == 0) ? 1 : int'(mod_value);
  endfunction

  function automatic int exp_at();
    int m;
    m = eff_mod();
    if (m_cur > m - 1) return 1;
    return up_down ? int'(m_cur == m - 1) : int'(m_cur == 0);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_advance();
    int m;
    m = eff_mod();
    m_wrap = 0;
    if (load) begin
      m_cur = (int'(load_value) < m) ? int'(load_value) : m - 1;
    end else if (tick) begin
      if (up_down) begin
        if (m_cur + 1 >= m) begin m_cur = 0; m_wrap = 1; end
        else m_cur = m_cur + 1;
      end else begin
        if (m_cur == 0 || m_cur >= m) begin m_cur = m - 1; m_wrap = 1; end
        else m_cur = m_cur - 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".cur"}, int'(cur_value), m_cur);
    check({tag, ".wrap"}, int'(wrap_pulse), m_wrap);
    check({tag, ".term"}, int'(at_terminal), exp_at());
  endtask

  task automatic step(input string tag);
    model_advance();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic t, input logic ud, input logic [3:0] md,
                       input logic ld, input logic [3:0] lv);
    tick = t; up_down = ud; mod_value = md; load = ld; load_value = lv;
  endtask

  initial begin
    int exp_dn [7];
    int exp_wr [7];
    exp_dn = '{4, 3, 2, 1, 0, 5, 4};
    exp_wr = '{0, 0, 0, 0, 0, 1, 0};

    resetn = 1'b0;
    drive(1'b0, 1'b0, 4'd6, 1'b0, 4'd0);
    c_tick = 1'b0; c_up = 1'b1; c_mod = 4'd10; c_load = 1'b0; c_lv = 4'd0;
    m_cur = 5; m_wrap = 0;

    // Reset state
    @(posedge clk); #3;
    check("rst.cur", int'(cur_value), 5);
    check("rst.wrap", int'(wrap_pulse), 0);
    check("rst.term", int'(at_terminal), 0);
    check("rst.c0", int'(c0_cur), 0);
`ifdef MOD_N_COUNTER_HEX_EN
    check("hex.5", int'(hex_seg), 7'b0010010);
    check("hex.0", int'(c0_hex), 7'b1000000);
`endif
    resetn = 1'b1;

    // Two-stage cascade, up mode, M = 10
    for (int i = 1; i <= 10; i++) begin
      c_tick = 1'b1;
      @(posedge clk); #1;
      check($sformatf("casc.c0.%0d", i), int'(c0_cur), i % 10);
      check($sformatf("casc.c0w.%0d", i), int'(c0_wrap), (i == 10) ? 1 : 0);
      check($sformatf("casc.c1.%0d", i), int'(c1_cur), 0);
    end
    c_tick = 1'b0;
    @(posedge clk); #1;
    check("casc.c0.hold", int'(c0_cur), 0);
    check("casc.c0w.once", int'(c0_wrap), 0);
    check("casc.c1.adv", int'(c1_cur), 1);
    check("casc.c1w", int'(c1_wrap), 0);

    // Down mode, M = 6, from reset value 5
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 4'd6, 1'b0, 4'd0);
      step($sformatf("down.%0d", i));
      check($sformatf("down.cur.%0d", i), int'(cur_value), exp_dn[i]);
      check($sformatf("down.wrap.%0d", i), int'(wrap_pulse), exp_wr[i]);
    end
    drive(1'b0, 1'b0, 4'd6, 1'b0, 4'd0);
    step("down.idle");

    // Load clamp, then load beating a same-cycle tick
    drive(1'b0, 1'b0, 4'd6, 1'b1, 4'd9);
    step("load.clamp");
    check("load.clamp.cur", int'(cur_value), 5);
    drive(1'b1, 1'b0, 4'd6, 1'b1, 4'd2);
    step("load.tick");
    check("load.tick.cur", int'(cur_value), 2);
    check("load.tick.wrap", int'(wrap_pulse), 0);

    // Modulus shrinks under an out-of-range count
    drive(1'b0, 1'b0, 4'd10, 1'b1, 4'd8);
    step("oor.load");
    drive(1'b0, 1'b0, 4'd4, 1'b0, 4'd0);
    #1;
    check("oor.term", int'(at_terminal), 1);
    drive(1'b1, 1'b0, 4'd4, 1'b0, 4'd0);
    step("oor.down");
    check("oor.down.cur", int'(cur_value), 3);
    check("oor.down.wrap", int'(wrap_pulse), 1);
    drive(1'b0, 1'b1, 4'd10, 1'b1, 4'd8);
    step("oor.reload");
    drive(1'b1, 1'b1, 4'd4, 1'b0, 4'd0);
    step("oor.up");
    check("oor.up.cur", int'(cur_value), 0);
    check("oor.up.wrap", int'(wrap_pulse), 1);

    // Degenerate moduli 0 and 1
    for (int md = 0; md < 2; md++) begin
      for (int k = 0; k < 2; k++) begin
        drive(1'b1, k[0], 4'(md), 1'b0, 4'd0);
        step($sformatf("m%0d.tick%0d", md, k));
        check($sformatf("m%0d.cur%0d", md, k), int'(cur_value), 0);
        check($sformatf("m%0d.wrap%0d", md, k), int'(wrap_pulse), 1);
      end
      drive(1'b0, 1'b0, 4'(md), 1'b0, 4'd0);
      step($sformatf("m%0d.idle", md));
      check($sformatf("m%0d.nowrap", md), int'(wrap_pulse), 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)));
      step($sformatf("rnd.%0d", i));
    end

    // Asynchronous reset while wrap_pulse is high
    drive(1'b1, 1'b0, 4'd1, 1'b0, 4'd0);
    step("ar.pre");
    check("ar.pre.wrap", int'(wrap_pulse), 1);
    #3;
    resetn = 1'b0;
    #1;
    check("ar.cur", int'(cur_value), 5);
    check("ar.wrap", int'(wrap_pulse), 0);
    @(posedge clk); #1;
    check("ar.hold.cur", int'(cur_value), 5);
    drive(1'b0, 1'b0, 4'd6, 1'b0, 4'd0);
    #2;
    resetn = 1'b1;
    #1;
    check("ar.rel.cur", int'(cur_value), 5);
    check("ar.rel.wrap", int'(wrap_pulse), 0);
    m_cur = 5; m_wrap = 0;
    drive(1'b1, 1'b0, 4'd6, 1'b0, 4'd0);
    step("ar.first");
    check("ar.first.cur", int'(cur_value), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
